aes_key_schedule: RTL and testbench

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

---
 rtl/aes_key_schedule_if.sv | 23 ++
 rtl/aes_key_schedule.sv | 142 ++++++++++++++
 tb/tb_aes_key_schedule.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_schedule_if.sv
// Request/readout bundle for the AES key schedule: start/key/round select in,
// round key, round validity and expansion status out.
interface aes_key_schedule_if #(
  parameter int unsigned KEY_BITS = 128
);
  logic                start;
  logic [KEY_BITS-1:0] init_key;
  logic [3:0]          round_number;
  logic [127:0]        round_key;
  logic                round_valid;
  logic                busy;
  logic                done;

  modport master (
    output start, init_key, round_number,
    input  round_key, round_valid, busy, done
  );

  modport slave (
    input  start, init_key, round_number,
    output round_key, round_valid, busy, done
  );
endinterface

// File: rtl/aes_key_schedule.sv
// Iterative AES key expansion (128/192/256-bit keys), one word per clock.
// Round keys are read combinationally from the word store and flagged valid
// as soon as their last word has been produced.
module aes_key_schedule #(
  parameter int unsigned KEY_BITS = 128
) (
  input logic               clk,
  input logic               reset,
  aes_key_schedule_if.slave bus
);
  localparam int unsigned NK = KEY_BITS / 32;
  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);
  localparam int unsigned IW = $clog2(NW + 1);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t        r_state;
  logic [IW-1:0] r_i;
  logic [2:0]    r_phase;
  logic [7:0]    r_rcon;
  logic          r_busy;
  logic          r_done;
  logic [31:0]   r_w [NW];

  logic          w_load;
  logic          w_step;
  logic [IW-1:0] w_idx_prev;
  logic [IW-1:0] w_idx_back;
  logic [31:0]   w_prev;
  logic [31:0]   w_sub_in;
  logic [31:0]   w_sub;
  logic [31:0]   w_temp;
  logic [7:0]    w_rcon_next;
  logic [5:0]    w_base;

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  assign w_load      = bus.start && (r_state != S_EXPAND);
  assign w_step      = (r_state == S_EXPAND);
  assign w_idx_prev  = r_i - IW'(1);
  assign w_idx_back  = r_i - IW'(NK);
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

  // Next-word temp: one shared 4-lookup SubWord serves both the rotated
  // (phase 0) and the plain (256-bit phase 4) substitution cases.
  always_comb begin
    w_prev   = r_w[w_idx_prev];
    w_sub_in = (r_phase == '0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_sub    = sub_word(w_sub_in);
    w_temp   = w_prev;
    if (r_phase == '0)
      w_temp = w_sub ^ {r_rcon, 24'h0};
    else if ((NK == 8) && (r_phase == 3'd4))
      w_temp = w_sub;
  end

  // Control FSM: word counter, phase (i mod Nk), Rcon and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_phase <= '0;
      r_rcon  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state <= S_EXPAND;
            r_i     <= IW'(NK);
            r_phase <= '0;
            r_rcon  <= 8'h01;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_EXPAND: begin
          r_i     <= r_i + IW'(1);
          r_phase <= (r_phase == 3'(NK - 1)) ? '0 : r_phase + 3'd1;
          if (r_phase == '0)
            r_rcon <= w_rcon_next;
          if (r_i == IW'(NW - 1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Word store: key load on an accepted start, one derived word per EXPAND cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NW; k++)
        r_w[k] <= '0;
    end else if (w_load) begin
      for (int unsigned k = 0; k < NK; k++)
        r_w[k] <= bus.init_key[KEY_BITS - 1 - 32 * k -: 32];
    end else if (w_step) begin
      r_w[r_i] <= r_w[w_idx_back] ^ w_temp;
    end
  end

  // Round readout. Words below r_i are exactly those written since the last
  // start, so validity needs no per-round flags.
  always_comb begin
    w_base          = {bus.round_number, 2'b00};
    bus.round_key   = '0;
    bus.round_valid = 1'b0;
    if (bus.round_number <= 4'(NR)) begin
      bus.round_key   = {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
      bus.round_valid = ({1'b0, w_base} + 7'd3) < 7'(r_i);
    end
  end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: one instance per key size, checked against a
// FIPS-197 style expansion model whose S-box is derived from GF(2^8) math.
module tb_aes_key_schedule;
  logic clk;
  logic reset;
  int   n_asserts = 0;
  int   n_fail    = 0;

  logic [7:0]  tb_sbox [256];
  logic [31:0] mw [3][60];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_schedule_if #(.KEY_BITS(128)) if128 ();
  aes_key_schedule_if #(.KEY_BITS(192)) if192 ();
  aes_key_schedule_if #(.KEY_BITS(256)) if256 ();

  aes_key_schedule #(.KEY_BITS(128)) u128 (.clk(clk), .reset(reset), .bus(if128));
  aes_key_schedule #(.KEY_BITS(192)) u192 (.clk(clk), .reset(reset), .bus(if192));
  aes_key_schedule #(.KEY_BITS(256)) u256 (.clk(clk), .reset(reset), .bus(if256));

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x, y;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = '0;
      for (int u = 1; u < 256; u++) begin
        y = 8'(u);
        if (x != 0 && gmul(x, y) == 8'h01) inv = y;
      end
      tb_sbox[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {tb_sbox[x[31:24]], tb_sbox[x[23:16]], tb_sbox[x[15:8]], tb_sbox[x[7:0]]};
  endfunction

  task automatic model_expand(input int s, input logic [255:0] key);
    int nk, nw;
    logic [31:0] t;
    logic [7:0]  rc;
    nk = 4 + 2 * s;
    nw = 4 * (nk + 7);
    for (int k = 0; k < 60; k++) mw[s][k] = '0;
    for (int k = 0; k < nk; k++) mw[s][k] = key[255 - 32 * k -: 32];
    rc = 8'h01;
    for (int i = nk; i < nw; i++) begin
      t = mw[s][i - 1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      mw[s][i] = mw[s][i - nk] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rkey(input int s, input int r);
    if (r > 10 + 2 * s) return '0;
    return {mw[s][4 * r], mw[s][4 * r + 1], mw[s][4 * r + 2], mw[s][4 * r + 3]};
  endfunction

  // ---------------- DUT access ----------------
  task automatic set_start(input int s, input logic v);
    case (s)
      0: if128.start = v;
      1: if192.start = v;
      default: if256.start = v;
    endcase
  endtask

  task automatic set_key(input int s, input logic [255:0] key);
    case (s)
      0: if128.init_key = key[255 -: 128];
      1: if192.init_key = key[255 -: 192];
      default: if256.init_key = key;
    endcase
  endtask

  task automatic set_rn(input int s, input logic [3:0] rn);
    case (s)
      0: if128.round_number = rn;
      1: if192.round_number = rn;
      default: if256.round_number = rn;
    endcase
  endtask

  function automatic logic get_busy(input int s);
    case (s)
      0: return if128.busy;
      1: return if192.busy;
      default: return if256.busy;
    endcase
  endfunction

  function automatic logic get_done(input int s);
    case (s)
      0: return if128.done;
      1: return if192.done;
      default: return if256.done;
    endcase
  endfunction

  function automatic logic get_rvalid(input int s);
    case (s)
      0: return if128.round_valid;
      1: return if192.round_valid;
      default: return if256.round_valid;
    endcase
  endfunction

  function automatic logic [127:0] get_rkey(input int s);
    case (s)
      0: return if128.round_key;
      1: return if192.round_key;
      default: return if256.round_key;
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int s, input logic [255:0] key);
    set_key(s, key);
    set_start(s, 1'b1);
    sync();
    set_start(s, 1'b0);
  endtask

  task automatic check_const(input int s, input int r, input logic [127:0] exp,
                             input logic exp_v, input string tag);
    set_rn(s, 4'(r));
    #1;
    check({tag, " key"}, get_rkey(s), exp);
    check({tag, " valid"}, 128'(get_rvalid(s)), 128'(exp_v));
  endtask

  task automatic check_rounds(input int s, input string tag);
    for (int r = 0; r < 16; r++) begin
      set_rn(s, 4'(r));
      #1;
      check($sformatf("%s r%0d key", tag, r), get_rkey(s), exp_rkey(s, r));
      check($sformatf("%s r%0d valid", tag, r), 128'(get_rvalid(s)), 128'(r <= 10 + 2 * s));
    end
    sync();
  endtask

  // Called #1 after the start edge with round_number already set to r.
  task automatic run_watch(input int s, input int r, input string tag);
    int nk, nr, nw, c, done_at;
    logic exp_v;
    nk = 4 + 2 * s; nr = nk + 6; nw = 4 * (nr + 1);
    c = 0; done_at = -1;
    while (c <= nw) begin
      exp_v = (r <= nr) && (4 * r + 3 < nk + c);
      check($sformatf("%s c%0d valid", tag, c), 128'(get_rvalid(s)), 128'(exp_v));
      if (exp_v || r > nr)
        check($sformatf("%s c%0d key", tag, c), get_rkey(s), exp_rkey(s, r));
      if (get_done(s)) begin
        done_at = c;
        break;
      end
      sync();
      c++;
    end
    check({tag, " done latency"}, 128'(done_at), 128'(nw - nk));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int first_done [3];
    int c;
    int r;
    logic [255:0] rk;

    reset = 1'b1;
    for (int s = 0; s < 3; s++) begin
      set_start(s, 1'b0);
      set_key(s, '0);
      set_rn(s, 4'd0);
    end
    build_sbox();
    model_expand(0, K128);
    model_expand(1, K192);
    model_expand(2, K256);
    sync();

    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset k%0d busy", 128 + 64 * s), 128'(get_busy(s)), '0);
      check($sformatf("reset k%0d done", 128 + 64 * s), 128'(get_done(s)), '0);
      check($sformatf("reset k%0d rkey", 128 + 64 * s), get_rkey(s), '0);
      check($sformatf("reset k%0d rvalid", 128 + 64 * s), 128'(get_rvalid(s)), '0);
    end
    sync();
    reset = 1'b0;
    sync();

    // Known-answer expansion on all three sizes at once; 128-bit holds round 1
    set_rn(0, 4'd1);
    set_rn(1, 4'd1);
    set_rn(2, 4'd2);
    set_key(0, K128);
    set_key(1, K192);
    set_key(2, K256);
    for (int s = 0; s < 3; s++) set_start(s, 1'b1);
    sync();
    for (int s = 0; s < 3; s++) set_start(s, 1'b0);
    first_done = '{-1, -1, -1};
    for (int cyc = 1; cyc <= 60; cyc++) begin
      sync();
      for (int s = 0; s < 3; s++)
        if (first_done[s] < 0 && get_done(s)) first_done[s] = cyc;
      if (get_busy(0))
        check($sformatf("kat128 r1 valid c%0d", cyc), 128'(get_rvalid(0)), 128'(cyc >= 4));
    end
    check("kat128 done latency", 128'(first_done[0]), 128'(40));
    check("kat192 done latency", 128'(first_done[1]), 128'(46));
    check("kat256 done latency", 128'(first_done[2]), 128'(52));
    check_const(0, 1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b1, "kat128 r1");
    check_const(0, 2, 128'hf2c295f27a96b9435935807a7359f67f, 1'b1, "kat128 r2");
    check_const(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, "kat128 r10");
    check_const(1, 1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5, 1'b1, "kat192 r1");
    check_const(1, 13, 128'h0, 1'b0, "kat192 r13");
    check_const(2, 2, 128'h9ba354118e6925afa51a8b5f2067fcde, 1'b1, "kat256 r2");
    check_const(2, 14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1, "kat256 r14");
    sync();
    check_rounds(0, "kat128");
    check_rounds(1, "kat192");
    check_rounds(2, "kat256");

    // Restart from DONE, then a stray start 10 clocks into the expansion
    set_rn(0, 4'd1);
    #1;
    check("restart r1 valid before", 128'(get_rvalid(0)), 128'(1));
    pulse_start(0, K128);
    check("restart done cleared", 128'(get_done(0)), '0);
    check("restart busy", 128'(get_busy(0)), 128'(1));
    check("restart r1 invalidated", 128'(get_rvalid(0)), '0);
    c = 0;
    while (!get_done(0) && c < 200) begin
      if (c == 10) begin
        for (int k = 0; k < 8; k++) rk[32 * k +: 32] = $urandom();
        set_key(0, rk);
        set_start(0, 1'b1);
      end
      sync();
      c++;
      set_start(0, 1'b0);
    end
    check("ignored start done latency", 128'(c), 128'(40));
    check_const(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, "ignored start r10");
    sync();
    check_rounds(0, "ignored start");

    // Asynchronous reset 20 clocks into an expansion
    for (int k = 0; k < 8; k++) rk[32 * k +: 32] = $urandom();
    set_rn(0, 4'd0);
    set_rn(2, 4'd14);
    pulse_start(0, rk);
    repeat (20) sync();
    #2;
    reset = 1'b1;
    #1;
    check("abort busy", 128'(get_busy(0)), '0);
    check("abort done", 128'(get_done(0)), '0);
    check("abort rkey", get_rkey(0), '0);
    check("abort rvalid", 128'(get_rvalid(0)), '0);
    check("abort k256 r14 valid", 128'(get_rvalid(2)), '0);
    sync();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sync();
      check($sformatf("post-abort idle busy %0d", k), 128'(get_busy(0)), '0);
      check($sformatf("post-abort idle done %0d", k), 128'(get_done(0)), '0);
    end
    set_rn(0, 4'd10);
    pulse_start(0, K128);
    run_watch(0, 10, "post-abort");
    check_const(0, 1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b1, "post-abort r1");
    check_const(0, 2, 128'hf2c295f27a96b9435935807a7359f67f, 1'b1, "post-abort r2");
    sync();

    // Random keys on every size, one watched round during expansion
    for (int n = 0; n < 3; n++) begin
      for (int s = 0; s < 3; s++) begin
        for (int k = 0; k < 8; k++) rk[32 * k +: 32] = $urandom();
        model_expand(s, rk);
        r = int'($urandom_range(0, 15));
        set_rn(s, 4'(r));
        pulse_start(s, rk);
        run_watch(s, r, $sformatf("rand%0d k%0d", n, 128 + 64 * s));
        check_rounds(s, $sformatf("rand%0d k%0d", n, 128 + 64 * s));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
